// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 stream core: initial hash value, round
// constants, FSM encoding and the unroll-factor legality check.
package sha256_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [255:0] H0 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  // Second-pass padding for SHA-256d: one 256-bit digest, so the length is 256 bits.
  localparam logic [31:0] PAD2_WORD = 32'h80000000;
  localparam logic [31:0] LEN2_WORD = 32'h00000100;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    return K_TAB[idx];
  endfunction

  // Unroll factor must divide 64 evenly and keep the round counter step a power of two.
  function automatic logic rpc_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8) || (r == 16);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one step of the rolling 16-word
// message schedule window (W[t] sits in the top word of sched_i).
module sha256_round (
  input  logic [255:0] state_i,
  input  logic [511:0] sched_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o,
  output logic [511:0] sched_o
);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w0, w1, w9, w14;
  logic [31:0] bsig0, bsig1, ch, maj, t1, t2;
  logic [31:0] ssig0, ssig1, w_new;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign w0  = sched_i[511:480];
  assign w1  = sched_i[479:448];
  assign w9  = sched_i[223:192];
  assign w14 = sched_i[63:32];

  assign bsig0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  assign bsig1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  assign ch    = (e & f) ^ (~e & g);
  assign maj   = (a & b) ^ (a & c) ^ (b & c);
  assign t1    = h + bsig1 + ch + k_i + w0;
  assign t2    = bsig0 + maj;

  // W[t+16] computed from the window; words produced past round 47 are never consumed.
  assign ssig0 = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
  assign ssig1 = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
  assign w_new = ssig1 + w9 + ssig0 + w0;

  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  assign sched_o = {sched_i[479:0], w_new};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 engine: pre-padded 512-bit blocks in, 256-bit digests out,
// multi-block chaining and optional SHA-256d, ROUNDS_PER_CYCLE rounds per clock.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int DOUBLE_HASH_EN   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_blk_data,
  input  logic         i_blk_first,
  input  logic         i_blk_last,
  input  logic         i_dbl,
  output logic         o_dig_valid,
  input  logic         i_dig_ready,
  output logic [255:0] o_digest,
  output logic         o_busy
);

  generate
    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  logic [1:0]   state_q, state_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [255:0] work_q, work_d;
  logic [511:0] sched_q, sched_d;
  logic [255:0] chain_q, chain_d;
  logic [255:0] digest_q, digest_d;
  logic         dig_valid_q, dig_valid_d;
  logic         last_q, last_d;
  logic         dbl_q, dbl_d;
  logic         pass2_q, pass2_d;

  logic         dbl_in;
  logic [255:0] sum_w;
  logic [255:0] st_chain [ROUNDS_PER_CYCLE+1];
  logic [511:0] sc_chain [ROUNDS_PER_CYCLE+1];

  generate
    if (DOUBLE_HASH_EN != 0) begin : g_dbl
      assign dbl_in = i_dbl & i_blk_last;
    end else begin : g_no_dbl
      assign dbl_in = 1'b0;
    end
  endgenerate

  assign st_chain[0] = work_q;
  assign sc_chain[0] = sched_q;

  generate
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      sha256_round u_round (
        .state_i (st_chain[gi]),
        .sched_i (sc_chain[gi]),
        .k_i     (k_const(rnd_q + 6'(gi))),
        .state_o (st_chain[gi+1]),
        .sched_o (sc_chain[gi+1])
      );
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sum
      assign sum_w[gi*32 +: 32] = work_q[gi*32 +: 32] + chain_q[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    sched_d     = sched_q;
    chain_d     = chain_q;
    digest_d    = digest_q;
    dig_valid_d = dig_valid_q;
    last_d      = last_q;
    dbl_d       = dbl_q;
    pass2_d     = pass2_q;
    case (state_q)
      ST_IDLE: begin
        if (i_blk_valid) begin
          sched_d = i_blk_data;
          last_d  = i_blk_last;
          dbl_d   = dbl_in;
          pass2_d = 1'b0;
          rnd_d   = 6'd0;
          // A first block restarts the message, so the chaining value becomes H0 too.
          if (i_blk_first) begin
            work_d  = H0;
            chain_d = H0;
          end else begin
            work_d = chain_q;
          end
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        work_d  = st_chain[ROUNDS_PER_CYCLE];
        sched_d = sc_chain[ROUNDS_PER_CYCLE];
        rnd_d   = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        chain_d = sum_w;
        if (!last_q) begin
          state_d = ST_IDLE;
        end else if (dbl_q && !pass2_q) begin
          sched_d = {sum_w, PAD2_WORD, 192'd0, LEN2_WORD};
          work_d  = H0;
          chain_d = H0;
          pass2_d = 1'b1;
          rnd_d   = 6'd0;
          state_d = ST_ROUND;
        end else begin
          digest_d    = sum_w;
          dig_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (i_dig_ready) begin
          dig_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= 6'd0;
      chain_q     <= H0;
      digest_q    <= '0;
      dig_valid_q <= 1'b0;
      last_q      <= 1'b0;
      dbl_q       <= 1'b0;
      pass2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      chain_q     <= chain_d;
      digest_q    <= digest_d;
      dig_valid_q <= dig_valid_d;
      last_q      <= last_d;
      dbl_q       <= dbl_d;
      pass2_q     <= pass2_d;
    end
  end

  // Datapath registers are always reloaded before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    work_q  <= work_d;
    sched_q <= sched_d;
  end

  assign o_blk_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dig_valid = dig_valid_q;
  assign o_digest    = digest_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed and randomized checks of sha256_stream_core against an array-based
// SHA-256 reference model with host-side padding.
module tb_sha256_stream_core;

  localparam int RPC  = 4;
  localparam int NCYC = 64 / RPC;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC_DBL_DIG =
    256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         dbl;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] digest;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [511:0] blks_q [$];
  logic [7:0]   msg_q  [$];

  always #5 clk = ~clk;

  sha256_stream_core #(
    .ROUNDS_PER_CYCLE (RPC),
    .DOUBLE_HASH_EN   (1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_blk_valid (blk_valid),
    .o_blk_ready (blk_ready),
    .i_blk_data  (blk_data),
    .i_blk_first (blk_first),
    .i_blk_last  (blk_last),
    .i_dbl       (dbl),
    .o_dig_valid (dig_valid),
    .i_dig_ready (dig_ready),
    .o_digest    (digest),
    .o_busy      (busy)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 over a list of padded blocks, full 64-word W expansion.
  function automatic logic [255:0] sha_model(input logic [511:0] blks [$]);
    logic [255:0] iv;
    logic [255:0] res;
    logic [31:0]  hv [8];
    logic [31:0]  v  [8];
    logic [31:0]  w  [64];
    logic [31:0]  t1, t2;
    logic [511:0] blk;
    iv = IV;
    for (int i = 0; i < 8; i++) hv[i] = iv[255-32*i -: 32];
    for (int b = 0; b < blks.size(); b++) begin
      blk = blks[b];
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hv[i];
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
        t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[i];
    return res;
  endfunction

  // Standard host-side padding: 0x80, zeros, 64-bit big-endian bit length.
  task automatic build_blocks(input logic [7:0] m [$]);
    logic [7:0]   p [$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    p = m;
    bitlen = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bitlen[63-8*i -: 8]);
    blks_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b + i];
      blks_q.push_back(blk);
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_block(input string tag, input logic [511:0] data,
                            input logic first, input logic last, input logic d);
    int n = 0;
    blk_valid = 1'b1;
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    dbl       = d;
    while (!blk_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_accept"}, {255'd0, blk_ready}, 256'd1);
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  // After a non-final block: no digest may appear, core returns to idle after N+1 cycles.
  task automatic wait_idle(input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!blk_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = seen | dig_valid;
    end
    check({tag, "_no_mid_digest"}, {255'd0, seen}, 256'd0);
    check({tag, "_mid_lat"}, 256'(n), 256'(NCYC + 1));
  endtask

  task automatic wait_digest(input string tag, input logic [255:0] exp, input int exp_lat);
    int lat = 0;
    while (!dig_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
    check({tag, "_digest"}, digest, exp);
    $display("[TB] %s lat=%0d digest=%h", tag, lat, digest);
  endtask

  task automatic take_digest(input string tag, input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    check({tag, "_released"}, {254'd0, dig_valid, blk_ready}, 256'd1);
  endtask

  task automatic run_message(input string tag, input logic d, input logic [255:0] exp,
                             input int exp_lat, input int hold);
    int nb = blks_q.size();
    for (int b = 0; b < nb; b++) begin
      send_block(tag, blks_q[b], b == 0, b == nb - 1, d);
      if (b != nb - 1) wait_idle(tag);
    end
    wait_digest(tag, exp, exp_lat);
    take_digest(tag, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string        two_str;
    logic [511:0] empty_blk;
    logic         stable;

    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0;
    blk_last = 1'b0; dbl = 1'b0; dig_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {255'd0, blk_ready}, 256'd1);
    check("rst_dig_valid", {255'd0, dig_valid}, 256'd0);
    check("rst_digest", digest, 256'd0);
    check("rst_busy", {255'd0, busy}, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    msg_q = '{8'h61, 8'h62, 8'h63};
    build_blocks(msg_q);
    run_message("abc", 1'b0, ABC_DIG, NCYC + 1, 0);

    msg_q.delete();
    build_blocks(msg_q);
    empty_blk = blks_q[0];
    run_message("empty", 1'b0, EMPTY_DIG, NCYC + 1, 1);

    two_str = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_q.delete();
    for (int i = 0; i < two_str.len(); i++) msg_q.push_back(two_str[i]);
    build_blocks(msg_q);
    run_message("two_block", 1'b0, TWO_DIG, NCYC + 1, 2);

    msg_q = '{8'h61, 8'h62, 8'h63};
    build_blocks(msg_q);
    run_message("abc_dbl", 1'b1, ABC_DBL_DIG, 2 * (NCYC + 1), 0);

    // Backpressure: digest held for 20 cycles while another block is offered.
    send_block("bp", blks_q[0], 1'b1, 1'b1, 1'b0);
    wait_digest("bp", ABC_DIG, NCYC + 1);
    blk_valid = 1'b1; blk_data = empty_blk; blk_first = 1'b1; blk_last = 1'b1; dbl = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (digest !== ABC_DIG || blk_ready !== 1'b0 || dig_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_hold_stable", {255'd0, stable}, 256'd1);
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    check("bp_release", {253'd0, dig_valid, blk_ready, busy}, 256'd2);
    @(posedge clk); #1;
    check("bp_next_accepted", {255'd0, busy}, 256'd1);
    blk_valid = 1'b0;
    wait_digest("bp_next", EMPTY_DIG, NCYC + 1);
    take_digest("bp_next", 0);

    // Reset in the middle of the rounds.
    send_block("rst_mid", blks_q[0], 1'b1, 1'b1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_mid_busy", {255'd0, busy}, 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs", {dig_valid, blk_ready, busy, 253'd0}, {1'b0, 1'b1, 1'b0, 253'd0});
    check("rst_mid_digest", digest, 256'd0);
    rst = 1'b0;
    run_message("abc_after_rst", 1'b0, ABC_DIG, NCYC + 1, 0);

    for (int it = 0; it < 12; it++) begin
      int           len;
      logic         d;
      logic [255:0] exp;
      logic [511:0] saved [$];
      logic [511:0] junk;
      len = $urandom_range(0, 130);
      d   = 1'($urandom_range(0, 1));
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      build_blocks(msg_q);
      exp = sha_model(blks_q);
      if (d) begin
        saved = blks_q;
        msg_q.delete();
        for (int i = 0; i < 32; i++) msg_q.push_back(exp[255-8*i -: 8]);
        build_blocks(msg_q);
        exp = sha_model(blks_q);
        blks_q = saved;
      end
      // Occasionally start an abandoned message first; the next first block must discard it.
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 16; i++) junk[32*i +: 32] = $urandom;
        send_block($sformatf("rnd%0d_junk", it), junk, 1'b1, 1'b0, 1'b0);
        wait_idle($sformatf("rnd%0d_junk", it));
      end
      run_message($sformatf("rnd%0d_len%0d_dbl%0d", it, len, d), d, exp,
                  d ? 2 * (NCYC + 1) : NCYC + 1, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
